// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch unit and the controller: opcode encodings,
// byte-sequencer states and the default bus widths.
package instr_fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OPCODE_W   = 3;

    typedef enum logic [OPCODE_W-1:0] {
        HLT  = 3'b000,
        SKZ  = 3'b001,
        ADD  = 3'b010,
        ANDD = 3'b011,
        XORR = 3'b100,
        LDA  = 3'b101,
        STO  = 3'b110,
        JMP  = 3'b111
    } opcode_e;

    typedef enum logic {
        SEQ_HI = 1'b0,
        SEQ_LO = 1'b1
    } seq_state_e;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// Program counter: hold, parallel load or increment; wraps silently at the top.
module pc_counter
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Load takes priority over increment when both strobes are present.
    always_comb begin
        pc_d = pc_q;
        if (en) begin
            if (load) begin
                pc_d = load_val;
            end else if (inc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: two-byte instruction register with byte sequencer,
// program counter, fetch/operand address mux and sticky halt / protocol flags.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                fetch,
    input  logic                inc_pc,
    input  logic                load_pc,
    input  logic                load_ir,
    input  logic                rd,
    input  logic                halt,
    input  logic [DATA_W-1:0]   data,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   ir_addr,
    output logic [ADDR_W-1:0]   pc_addr,
    output logic [ADDR_W-1:0]   addr,
    output logic                ir_valid,
    output logic                halted,
    output logic                proto_err
);

    localparam int unsigned IR_W = 2 * DATA_W;

    seq_state_e        seq_d,       seq_q;
    logic [IR_W-1:0]   ir_d,        ir_q;
    logic              ir_valid_d,  ir_valid_q;
    logic              halted_d,    halted_q;
    logic              proto_err_d, proto_err_q;
    logic              pc_en;

    always_comb begin
        seq_d       = seq_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        halted_d    = halted_q;
        proto_err_d = proto_err_q;

        if (!ena) begin
            seq_d      = SEQ_HI;
            ir_valid_d = 1'b0;
        end else begin
            if (halt) begin
                halted_d = 1'b1;
            end
            // The registered halt gates capture, so a byte arriving on the
            // halting edge itself is still taken.
            if (!halted_q) begin
                if (load_ir && rd) begin
                    case (seq_q)
                        SEQ_HI: begin
                            ir_d[IR_W-1:DATA_W] = data;
                            ir_valid_d          = 1'b0;
                            seq_d               = SEQ_LO;
                        end
                        default: begin
                            ir_d[DATA_W-1:0] = data;
                            ir_valid_d       = 1'b1;
                            seq_d            = SEQ_HI;
                        end
                    endcase
                end else if (load_ir) begin
                    proto_err_d = 1'b1;
                end else if (seq_q == SEQ_LO) begin
                    seq_d = SEQ_HI;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q       <= SEQ_HI;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            halted_q    <= halted_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign pc_en = ena && !halted_q && !halt;

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (pc_en),
        .load     (load_pc),
        .inc      (inc_pc),
        .load_val (ir_q[ADDR_W-1:0]),
        .pc       (pc_addr)
    );

    assign opcode    = ir_q[IR_W-1 -: OPCODE_W];
    assign ir_addr   = ir_q[ADDR_W-1:0];
    assign addr      = fetch ? pc_addr : ir_addr;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run compared cycle by cycle against an arithmetic reference model.
module tb_instr_fetch;

    localparam int AW     = 13;
    localparam int DW     = 8;
    localparam int PC_MOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b1;
    logic          fetch = 1'b0;
    logic          inc_pc = 1'b0;
    logic          load_pc = 1'b0;
    logic          load_ir = 1'b0;
    logic          rd = 1'b0;
    logic          halt = 1'b0;
    logic [DW-1:0] data = '0;
    logic [2:0]    opcode;
    logic [AW-1:0] ir_addr;
    logic [AW-1:0] pc_addr;
    logic [AW-1:0] addr;
    logic          ir_valid;
    logic          halted;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: IR as a 16-bit number, PC as an integer,
    // whether a high byte is waiting for its partner, and the flags.
    int m_ir, m_pc, m_hi_taken, m_valid, m_halt, m_perr;

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .fetch     (fetch),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .load_ir   (load_ir),
        .rd        (rd),
        .halt      (halt),
        .data      (data),
        .opcode    (opcode),
        .ir_addr   (ir_addr),
        .pc_addr   (pc_addr),
        .addr      (addr),
        .ir_valid  (ir_valid),
        .halted    (halted),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic drive(input logic li, input logic r, input logic [DW-1:0] d,
                         input logic lp, input logic ip, input logic h);
        load_ir = li; rd = r; data = d; load_pc = lp; inc_pc = ip; halt = h;
    endtask

    // Advance one rising edge, apply the rules to the model, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (ena && !m_halt && !halt) begin
            if (load_pc)     m_pc = m_ir % PC_MOD;
            else if (inc_pc) m_pc = (m_pc + 1) % PC_MOD;
        end
        if (!ena) begin
            m_hi_taken = 0;
            m_valid    = 0;
        end else begin
            if (!m_halt) begin
                if (load_ir && rd) begin
                    if (m_hi_taken == 0) begin
                        m_ir = int'(data) * 256 + (m_ir % 256);
                        m_valid = 0;
                        m_hi_taken = 1;
                    end else begin
                        m_ir = (m_ir / 256) * 256 + int'(data);
                        m_valid = 1;
                        m_hi_taken = 0;
                    end
                end else if (load_ir) begin
                    m_perr = 1;
                end else begin
                    m_hi_taken = 0;
                end
            end
            if (halt) m_halt = 1;
        end
        @(negedge clk);
    endtask

    task automatic load_word(input logic [15:0] w);
        drive(1'b1, 1'b1, w[15:8], 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, w[7:0],  1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, '0,      1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset away from the clock edge and checks outputs clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({opcode, ir_addr, pc_addr, ir_valid, halted, proto_err} !== '0) begin
            errors++;
            $display("FAIL reset_clear: op=%0h ir_addr=%0h pc=%0h v=%0b h=%0b pe=%0b, required all zero",
                     opcode, ir_addr, pc_addr, ir_valid, halted, proto_err);
        end
        checks++;
        if (addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %0h required 0", addr);
        end
        m_ir = 0; m_pc = 0; m_hi_taken = 0; m_valid = 0; m_halt = 0; m_perr = 0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        ena = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        tick();
        checks++;
        if ({opcode, ir_addr} !== 16'h0000 || pc_addr !== '0 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ir=%0h pc=%0h v=%0b required 0/0/0", {opcode, ir_addr}, pc_addr, ir_valid);
        end
    endtask

    task automatic test_ir_load();
        do_reset();
        drive(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0); tick();
        checks++;
        if (ir_valid !== 1'b0 || {opcode, ir_addr[12:8]} !== 8'hA0) begin
            errors++;
            $display("FAIL ir_hi_byte: v=%0b hi=%0h required 0/a0", ir_valid, {opcode, ir_addr[12:8]});
        end
        drive(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (opcode !== 3'b101 || ir_addr !== 13'h0005 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL ir_word: op=%0b ir_addr=%0h v=%0b required 101/0005/1", opcode, ir_addr, ir_valid);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        load_word(16'h1FFF);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        checks++;
        if (pc_addr !== 13'h1FFF) begin
            errors++;
            $display("FAIL pc_load_max: got %0h required 1fff", pc_addr);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
        checks++;
        if (pc_addr !== 13'h0000) begin
            errors++;
            $display("FAIL pc_wrap: got %0h required 0000", pc_addr);
        end
        load_word(16'h0123);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_addr !== 13'h0123 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL pc_load_wins: pc=%0h pe=%0b required 0123/0", pc_addr, proto_err);
        end
    endtask

    task automatic test_abort();
        do_reset();
        drive(1'b1, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
        checks++;
        if (ir_valid !== 1'b0 || {opcode, ir_addr[12:8]} !== 8'hE0) begin
            errors++;
            $display("FAIL abort_hold: v=%0b hi=%0h required 0/e0", ir_valid, {opcode, ir_addr[12:8]});
        end
        load_word(16'h2010);
        checks++;
        if ({opcode, ir_addr} !== 16'h2010 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_refetch: ir=%0h v=%0b required 2010/1", {opcode, ir_addr}, ir_valid);
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (4) begin
            drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
        end
        checks++;
        if (pc_addr !== 13'h0004) begin
            errors++;
            $display("FAIL halt_pre_pc: got %0h required 0004", pc_addr);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1); tick();
        checks++;
        if (halted !== 1'b1 || pc_addr !== 13'h0004) begin
            errors++;
            $display("FAIL halt_edge: h=%0b pc=%0h required 1/0004", halted, pc_addr);
        end
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0); tick(); tick(); tick();
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({opcode, ir_addr} !== 16'h0000 || pc_addr !== 13'h0004 || ir_valid !== 1'b0
            || halted !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL halt_frozen: ir=%0h pc=%0h v=%0b h=%0b pe=%0b required 0000/0004/0/1/0",
                     {opcode, ir_addr}, pc_addr, ir_valid, halted, proto_err);
        end
    endtask

    task automatic test_proto_ena();
        do_reset();
        load_word(16'hA005);
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0); tick();
        checks++;
        if ({opcode, ir_addr} !== 16'hA005 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_err: ir=%0h pe=%0b required a005/1", {opcode, ir_addr}, proto_err);
        end
        drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0); tick();
        ena = 1'b0;
        drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0); tick();
        ena = 1'b1;
        checks++;
        if (ir_valid !== 1'b0 || pc_addr !== 13'h0000 || {opcode, ir_addr} !== 16'h3305) begin
            errors++;
            $display("FAIL ena_low: v=%0b pc=%0h ir=%0h required 0/0000/3305", ir_valid, pc_addr, {opcode, ir_addr});
        end
        load_word(16'h1234);
        checks++;
        if ({opcode, ir_addr} !== 16'h1234 || ir_valid !== 1'b1 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL ena_resume: ir=%0h v=%0b pe=%0b required 1234/1/1", {opcode, ir_addr}, ir_valid, proto_err);
        end
    endtask

    task automatic test_fetch_mux();
        do_reset();
        load_word(16'h0010);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        load_word(16'h0ABC);
        for (int i = 0; i < 4; i++) begin
            fetch = (i % 2 == 0);
            #1;
            checks++;
            if (addr !== (fetch ? 13'h0010 : 13'h0ABC)) begin
                errors++;
                $display("FAIL fetch_mux[%0d]: fetch=%0b addr=%0h required %0h", i, fetch, addr,
                         fetch ? 13'h0010 : 13'h0ABC);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_lo();
        do_reset();
        load_word(16'h5A5A);
        drive(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0); tick();
        fetch = 1'b1;
        do_reset();
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({opcode, ir_addr} !== 16'h7700 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_lo: ir=%0h v=%0b required 7700/0", {opcode, ir_addr}, ir_valid);
        end
    endtask

    task automatic test_random();
        logic [2:0]    e_op;
        logic [AW-1:0] e_ia, e_pc, e_addr;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ((m_halt != 0 && $urandom_range(3) == 0) || $urandom_range(149) == 0) do_reset();
            ena   = ($urandom_range(7) != 0);
            fetch = $urandom_range(1);
            drive($urandom_range(3) != 0, $urandom_range(7) != 0, DW'($urandom),
                  $urandom_range(5) == 0, $urandom_range(1), $urandom_range(47) == 0);
            tick();
            e_op = 3'(m_ir / 8192);
            e_ia = AW'(m_ir % 8192);
            e_pc = AW'(m_pc);
            e_addr = fetch ? e_pc : e_ia;
            checks++;
            if (opcode !== e_op || ir_addr !== e_ia) begin
                errors++;
                $display("FAIL rand_ir[%0d]: ir=%0h required %0h", n, {opcode, ir_addr}, {e_op, e_ia});
            end
            checks++;
            if (pc_addr !== e_pc) begin
                errors++;
                $display("FAIL rand_pc[%0d]: pc=%0h required %0h", n, pc_addr, e_pc);
            end
            checks++;
            if (addr !== e_addr) begin
                errors++;
                $display("FAIL rand_addr[%0d]: addr=%0h required %0h", n, addr, e_addr);
            end
            checks++;
            if (ir_valid !== 1'(m_valid) || halted !== 1'(m_halt) || proto_err !== 1'(m_perr)) begin
                errors++;
                $display("FAIL rand_flags[%0d]: v/h/pe=%0b%0b%0b required %0b%0b%0b", n,
                         ir_valid, halted, proto_err, 1'(m_valid), 1'(m_halt), 1'(m_perr));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ir_load();
        test_pc_wrap();
        test_abort();
        test_halt();
        test_proto_ena();
        test_fetch_mux();
        test_reset_mid_lo();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, 13, width of program counter and operand address.
REQ-002 Parameter DATA_W, 8, width of the memory data bus; instruction is 2*DATA_W bits.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ena  in  1  run enable from clock generator; low = synchronous idle.
REQ-007 fetch  in  1  address-select phase: 1 = instruction fetch, 0 = operand access.
REQ-008 inc_pc, load_pc, load_ir, rd, halt  in  1 each  control strobes from controller (driven on falling edge).
REQ-009 data  in  DATA_W  memory read data.
REQ-010 opcode  out  3  IR[15:13].
REQ-011 ir_addr  out  ADDR_W  IR[12:0].
REQ-012 pc_addr  out  ADDR_W  current program counter.
REQ-013 addr  out  ADDR_W  memory address: pc_addr when fetch=1, else ir_addr (combinational).
REQ-014 ir_valid  out  1  both instruction bytes captured since last fetch start.
REQ-015 halted  out  1  sticky halt indication.
REQ-016 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-017 Byte sequencer SHALL have two states: HI (expect high byte) and LO (expect low byte).
REQ-018 In HI, a rising edge with ena=1, load_ir=1, rd=1, halted=0 SHALL capture data into IR[15:8], clear ir_valid, go to LO.
REQ-019 In LO, a rising edge with ena=1, load_ir=1, rd=1, halted=0 SHALL capture data into IR[7:0], set ir_valid, go to HI.
REQ-020 In LO, load_ir=0 on a rising edge SHALL abort the fetch: return to HI, ir_valid stays 0, IR[15:8] retained.
REQ-021 load_ir=1 with rd=0 SHALL not modify IR or sequencer state and SHALL set proto_err.
REQ-022 PC update priority per rising edge: ena=0 or halted or halt -> hold; else load_pc -> PC=ir_addr; else inc_pc -> PC+1; else hold.
REQ-023 PC increment SHALL wrap 2^ADDR_W-1 -> 0 without any flag.
REQ-024 load_pc and inc_pc asserted together SHALL load (load wins), no error.
REQ-025 halt=1 with ena=1 SHALL set halted on that edge; PC does not change on that edge even if inc_pc=1.
REQ-026 While halted=1: PC, IR, sequencer frozen; addr still muxes on fetch.
REQ-027 ena=0 on a rising edge SHALL force sequencer to HI and clear ir_valid; PC, IR, halted, proto_err hold.
REQ-028 opcode and ir_addr SHALL reflect IR register contents directly; no additional latency.
REQ-029 Latency: ir_valid high the cycle after the second capture edge; PC new value visible the cycle after the strobe edge.

Reset
REQ-030 rst_n low SHALL asynchronously set PC=0, IR=0, sequencer=HI, ir_valid=0, halted=0, proto_err=0.
REQ-031 Reset mid-fetch (sequencer LO) SHALL discard the captured high byte (IR=0).
REQ-032 Deassertion of rst_n SHALL be honoured at the next rising edge; no further reset only via rst_n.

Structure
REQ-033 Shared package holds opcode constants HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111, plus ADDR_W/DATA_W defaults; controller and this block use it.
REQ-034 Program counter SHALL be a sub-module pc_counter (load, inc, hold, wrap); IR, sequencer and address mux stay in instr_fetch.

Verification
REQ-035 Reset, then two load_ir+rd edges with data=0xA0 then 0x05 -> IR=0xA005, opcode=101, ir_addr=0x0005, ir_valid=1.
REQ-036 PC=0x1FFF, inc_pc pulse -> PC=0x0000; load_pc+inc_pc with ir_addr=0x0123 -> PC=0x0123.
REQ-037 After high byte 0xE0, load_ir drops -> sequencer HI, ir_valid=0; next pair 0x20,0x10 -> IR=0x2010.
REQ-038 halt with inc_pc at PC=0x0004 -> halted=1, PC stays 0x0004; further load_ir/inc_pc ignored until rst_n.
REQ-039 load_ir=1, rd=0 -> IR unchanged, proto_err=1; ena low mid-fetch -> ir_valid=0, PC held.
REQ-040 fetch toggling with PC=0x0010, ir_addr=0x0ABC -> addr alternates 0x0010/0x0ABC same cycle; rst_n low mid-LO -> all outputs zero immediately.
